wb_writer: RTL

Writeback stage of the 5-stage pipeline and the sole writer of the register file. Holds the MEM/WB pipeline register, selects and formats the result (ALU, sign/zero-extended load data, or PC+4), and drives the register file write port (`RegWrite`, `rd_addr`, `Din`). It also exposes the same value as a forwarding source for decode/execute, and keeps a 64-bit retired-instruction counter.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_writer_load_extend.sv | 37 +++
 rtl/wb_writer.sv | 93 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage: result-select codes,
// load funct3 encodings and the control half of the MEM/WB register.
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // fresh marks the first cycle an instruction sits in WB; only then may it write
  typedef struct packed {
    logic       valid;
    logic       fresh;
    logic       reg_write;
    logic [4:0] rd;
  } wb_ctl_t;

endpackage

// File: rtl/wb_writer_load_extend.sv
// Load result formatting: picks the byte/half lane from the aligned memory
// word and sign- or zero-extends it; any other funct3 passes the word through.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// Writeback stage: MEM/WB register with result formatting on capture, the
// register-file write port, a forwarding tap and the retired-instruction counter.
module wb_writer
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd_addr,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic             stall,
  input  logic             flush,
  output logic             RegWrite,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  Din,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  wb_ctl_t          ctl_q, ctl_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  load_val, fmt_val;
  logic             pending;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (mem_funct3),
    .addr   (mem_alu_result[1:0]),
    .word   (mem_load_data),
    .data   (load_val)
  );

  always_comb begin
    case (mem_wb_sel)
      WB_SEL_LOAD: fmt_val = load_val;
      WB_SEL_PC4:  fmt_val = mem_pc + XLEN'(4);
      default:     fmt_val = mem_alu_result;
    endcase
  end

  // Flush outranks stall; a stalled entry keeps its value but loses fresh,
  // which limits each instruction to a single write pulse.
  always_comb begin
    ctl_d    = ctl_q;
    result_d = result_q;
    if (flush) begin
      ctl_d.valid     = 1'b0;
      ctl_d.fresh     = 1'b0;
      ctl_d.reg_write = 1'b0;
    end else if (stall) begin
      ctl_d.fresh = 1'b0;
    end else begin
      ctl_d.valid     = mem_valid;
      ctl_d.fresh     = mem_valid;
      ctl_d.reg_write = mem_reg_write;
      ctl_d.rd        = mem_rd_addr;
      result_d        = fmt_val;
    end
    instret_d = (ctl_q.valid & ctl_q.fresh) ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q     <= '0;
      result_q  <= '0;
      instret_q <= '0;
    end else begin
      ctl_q     <= ctl_d;
      result_q  <= result_d;
      instret_q <= instret_d;
    end
  end

  assign pending   = ctl_q.valid & ctl_q.reg_write & (ctl_q.rd != 5'd0);
  assign RegWrite  = pending & ctl_q.fresh;
  assign rd_addr   = ctl_q.rd;
  assign Din       = result_q;
  assign fwd_valid = pending;
  assign fwd_rd    = ctl_q.rd;
  assign fwd_data  = result_q;
  assign instret   = instret_q;

endmodule
